i2s_tx_feeder: RTL and testbench

Frame-synchronous sample scheduler for the I2S transmit path. Arbitrates round-robin between two stereo sample sources (valid/ready) into a small stereo-pair FIFO. Presents exactly one new left/right pair to the `i2s_tx` channel inputs per LRCLK frame. Also owns the transmit prescaler configuration and detects and counts underruns. It sits between the audio sources and `i2s_tx` in the same `i_tx_sclk` domain.

---
 rtl/i2s_pkg.sv | 20 ++
 rtl/i2s_pair_fifo.sv | 58 +++++
 rtl/i2s_tx_feeder.sv | 135 +++++++++++++
 tb/tb_i2s_tx_feeder.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/i2s_pkg.sv
// Shared definitions for the I2S transmit feeder: FSM encoding, counter width
// and stereo pair sizing.
package i2s_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRIME = 2'd1,
    ST_RUN   = 2'd2
  } feeder_state_t;

  localparam int UNDERRUN_CNT_W = 8;
  localparam int DEF_AUDIO_DW   = 16;
  localparam int DEF_FIFO_DEPTH = 4;

  // A stereo pair is stored as {left, right}.
  function automatic int pair_width(input int dw);
    return 2 * dw;
  endfunction

endpackage

// File: rtl/i2s_pair_fifo.sv
// Synchronous FIFO of {left, right} stereo pairs. The level is kept separately
// from the pointers; there is no same-cycle push-to-pop bypass.
module i2s_pair_fifo
  import i2s_pkg::*;
#(
  parameter int PAIR_W = pair_width(DEF_AUDIO_DW),
  parameter int DEPTH  = DEF_FIFO_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   push,
  input  logic [PAIR_W-1:0]      push_data,
  input  logic                   pop,
  output logic [PAIR_W-1:0]      head_data,
  output logic [$clog2(DEPTH):0] level,
  output logic                   full,
  output logic                   empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = DEPTH[AW:0];

  logic [PAIR_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr_reg;
  logic [AW-1:0]     rd_ptr_reg;
  logic [AW:0]       level_reg;
  logic              push_ok;
  logic              pop_ok;

  // Full/empty come from the pre-edge level, so a pop never frees a slot
  // for a push in the same cycle.
  assign full      = (level_reg == FULL_LVL);
  assign empty     = (level_reg == '0);
  assign push_ok   = push & ~full;
  assign pop_ok    = pop & ~empty;
  assign head_data = mem[rd_ptr_reg];
  assign level     = level_reg;

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr_reg] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      level_reg <= level_reg + {{AW{1'b0}}, push_ok} - {{AW{1'b0}}, pop_ok};
    end
  end

endmodule

// File: rtl/i2s_tx_feeder.sv
// Frame-synchronous sample scheduler: round-robin intake from two stereo
// sources, one pair presented to the transmitter per LRCLK frame.
module i2s_tx_feeder
  import i2s_pkg::*;
#(
  parameter int AUDIO_DW   = DEF_AUDIO_DW,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                        i_tx_sclk,
  input  logic                        i_rst_n,
  input  logic                        i_enable,
  input  logic [AUDIO_DW-1:0]         i_cfg_prescaler,
  input  logic                        i_lrclk,
  input  logic                        i_src0_valid,
  input  logic [AUDIO_DW-1:0]         i_src0_left,
  input  logic [AUDIO_DW-1:0]         i_src0_right,
  input  logic                        i_src1_valid,
  input  logic [AUDIO_DW-1:0]         i_src1_left,
  input  logic [AUDIO_DW-1:0]         i_src1_right,
  output logic                        o_src0_ready,
  output logic                        o_src1_ready,
  output logic [AUDIO_DW-1:0]         o_tx_prescaler,
  output logic [AUDIO_DW-1:0]         o_tx_left_chan,
  output logic [AUDIO_DW-1:0]         o_tx_right_chan,
  output logic [$clog2(FIFO_DEPTH):0] o_fifo_level,
  output logic                        o_underrun,
  output logic [UNDERRUN_CNT_W-1:0]   o_underrun_cnt,
  output logic                        o_running
);

  localparam int PAIR_W = pair_width(AUDIO_DW);

  feeder_state_t             state_reg, state_next;
  logic                      lrclk_q;
  logic                      frame_stb;
  logic                      fifo_full, fifo_empty;
  logic [PAIR_W-1:0]         head_pair, push_pair;
  logic                      grant0, grant1, active;
  logic                      pop_req, underrun_hit;
  logic                      last_src1_reg;
  logic [AUDIO_DW-1:0]       prescaler_reg, left_reg, right_reg;
  logic                      underrun_reg;
  logic [UNDERRUN_CNT_W-1:0] underrun_cnt_reg;

  assign frame_stb = lrclk_q & ~i_lrclk;

  always_ff @(posedge i_tx_sclk) begin
    if (!i_rst_n) state_reg <= ST_IDLE;
    else          state_reg <= state_next;
  end

  always_comb begin
    state_next   = state_reg;
    active       = (state_reg == ST_PRIME) || (state_reg == ST_RUN);
    grant0       = 1'b0;
    grant1       = 1'b0;
    pop_req      = 1'b0;
    underrun_hit = 1'b0;
    case (state_reg)
      ST_IDLE:  if (i_enable) state_next = ST_PRIME;
      ST_PRIME: if (frame_stb && !fifo_empty) state_next = ST_RUN;
      ST_RUN:   state_next = ST_RUN;
      default:  state_next = ST_IDLE;
    endcase
    if (!i_enable) state_next = ST_IDLE;
    // last_src1_reg high means src0 has priority on a tie.
    if (active && !fifo_full) begin
      grant0 = i_src0_valid && (!i_src1_valid || last_src1_reg);
      grant1 = i_src1_valid && (!i_src0_valid || !last_src1_reg);
    end
    pop_req      = i_enable && active && frame_stb && !fifo_empty;
    underrun_hit = i_enable && (state_reg == ST_RUN) && frame_stb && fifo_empty;
  end

  assign push_pair = grant0 ? {i_src0_left, i_src0_right} : {i_src1_left, i_src1_right};

  i2s_pair_fifo #(
    .PAIR_W (PAIR_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk       (i_tx_sclk),
    .rst_n     (i_rst_n),
    .flush     (~i_enable),
    .push      (grant0 | grant1),
    .push_data (push_pair),
    .pop       (pop_req),
    .head_data (head_pair),
    .level     (o_fifo_level),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_ff @(posedge i_tx_sclk) begin
    if (!i_rst_n) begin
      lrclk_q          <= 1'b0;
      last_src1_reg    <= 1'b1;
      prescaler_reg    <= '0;
      left_reg         <= '0;
      right_reg        <= '0;
      underrun_reg     <= 1'b0;
      underrun_cnt_reg <= '0;
    end else begin
      lrclk_q      <= i_lrclk;
      underrun_reg <= underrun_hit;
      if (state_reg == ST_IDLE) prescaler_reg <= i_cfg_prescaler;
      if (!i_enable) begin
        last_src1_reg    <= 1'b1;
        left_reg         <= '0;
        right_reg        <= '0;
        underrun_cnt_reg <= '0;
      end else begin
        if (grant0)      last_src1_reg <= 1'b0;
        else if (grant1) last_src1_reg <= 1'b1;
        if (pop_req) begin
          left_reg  <= head_pair[PAIR_W-1:AUDIO_DW];
          right_reg <= head_pair[AUDIO_DW-1:0];
        end else if (underrun_hit) begin
          left_reg  <= '0;
          right_reg <= '0;
          if (underrun_cnt_reg != '1) underrun_cnt_reg <= underrun_cnt_reg + 1'b1;
        end
      end
    end
  end

  assign o_src0_ready    = grant0;
  assign o_src1_ready    = grant1;
  assign o_tx_prescaler  = prescaler_reg;
  assign o_tx_left_chan  = left_reg;
  assign o_tx_right_chan = right_reg;
  assign o_underrun      = underrun_reg;
  assign o_underrun_cnt  = underrun_cnt_reg;
  assign o_running       = (state_reg == ST_RUN);

endmodule

// File: tb/tb_i2s_tx_feeder.sv
// Directed bench for i2s_tx_feeder: reset/idle, streaming, round-robin,
// underrun saturation, disable and mid-transfer reset.
module tb_i2s_tx_feeder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic [15:0] cfg = 16'd8;
  logic        lrclk = 1'b0;
  logic        v0 = 1'b0, v1 = 1'b0;
  logic [15:0] s0l = '0, s0r = '0, s1l = '0, s1r = '0;
  logic        r0, r1;
  logic [15:0] presc, left, right;
  logic [2:0]  level;
  logic        underrun;
  logic [7:0]  ucnt;
  logic        running;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  i2s_tx_feeder dut (
    .i_tx_sclk       (clk),
    .i_rst_n         (rst_n),
    .i_enable        (enable),
    .i_cfg_prescaler (cfg),
    .i_lrclk         (lrclk),
    .i_src0_valid    (v0),
    .i_src0_left     (s0l),
    .i_src0_right    (s0r),
    .i_src1_valid    (v1),
    .i_src1_left     (s1l),
    .i_src1_right    (s1r),
    .o_src0_ready    (r0),
    .o_src1_ready    (r1),
    .o_tx_prescaler  (presc),
    .o_tx_left_chan  (left),
    .o_tx_right_chan (right),
    .o_fifo_level    (level),
    .o_underrun      (underrun),
    .o_underrun_cnt  (ucnt),
    .o_running       (running)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Two cycles of LRCLK high, then drop it; the strobe is live on return.
  task automatic lr_prep();
    lrclk = 1'b1;
    tick();
    tick();
    lrclk = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    // Reset and idle
    tick();
    tick();
    chk("rst_presc", presc, 0);
    chk("rst_level", level, 0);
    chk("rst_running", running, 0);
    rst_n = 1'b1;
    tick();
    chk("idle_presc", presc, 16'd8);
    chk("idle_left", left, 0);
    v0 = 1'b1; v1 = 1'b1;
    #1;
    chk("idle_r0", r0, 0);
    chk("idle_r1", r1, 0);
    v0 = 1'b0; v1 = 1'b0;

    // Basic stream
    enable = 1'b1;
    tick();
    chk("prime_running", running, 0);
    v0 = 1'b1; s0l = 16'h1111; s0r = 16'h2222;
    #1;
    chk("prime_r0", r0, 1);
    tick();
    chk("push1_level", level, 1);
    s0l = 16'h3333; s0r = 16'h4444;
    tick();
    v0 = 1'b0;
    chk("push2_level", level, 2);
    cfg = 16'd5;
    tick();
    chk("presc_hold", presc, 16'd8);
    lr_prep();
    chk("stb_hold_left", left, 0);
    tick();
    chk("f1_left", left, 16'h1111);
    chk("f1_right", right, 16'h2222);
    chk("f1_level", level, 1);
    chk("f1_running", running, 1);
    lr_prep();
    tick();
    chk("f2_left", left, 16'h3333);
    chk("f2_right", right, 16'h4444);
    chk("f2_level", level, 0);

    // Underrun
    lr_prep();
    tick();
    chk("ur_left", left, 0);
    chk("ur_right", right, 0);
    chk("ur_pulse", underrun, 1);
    chk("ur_cnt1", ucnt, 1);
    chk("ur_running", running, 1);
    tick();
    chk("ur_pulse_end", underrun, 0);
    for (int i = 0; i < 299; i++) begin
      lr_prep();
      tick();
    end
    chk("ur_cnt_sat", ucnt, 8'd255);
    v1 = 1'b1; s1l = 16'hAAAA; s1r = 16'hBBBB;
    #1;
    chk("resume_r1", r1, 1);
    tick();
    v1 = 1'b0;
    lr_prep();
    tick();
    chk("resume_left", left, 16'hAAAA);
    chk("resume_right", right, 16'hBBBB);
    chk("resume_ur", underrun, 0);
    chk("resume_cnt", ucnt, 8'd255);

    // Round-robin with both sources valid
    v0 = 1'b1; s0l = 16'h1000; s0r = 16'h1001;
    v1 = 1'b1; s1l = 16'h2000; s1r = 16'h2001;
    #1;
    chk("rr0_r0", r0, 1);
    chk("rr0_r1", r1, 0);
    tick();
    chk("rr1_r0", r0, 0);
    chk("rr1_r1", r1, 1);
    tick();
    chk("rr2_r0", r0, 1);
    tick();
    chk("rr3_r1", r1, 1);
    tick();
    chk("rr_full_level", level, 4);
    chk("rr_full_r0", r0, 0);
    chk("rr_full_r1", r1, 0);
    lr_prep();
    chk("rr_popcyc_level", level, 4);
    chk("rr_popcyc_r0", r0, 0);
    chk("rr_popcyc_r1", r1, 0);
    tick();
    chk("rr_pop1_left", left, 16'h1000);
    chk("rr_pop1_level", level, 3);
    chk("rr_pop1_r0", r0, 1);
    tick();
    chk("rr_refill_level", level, 4);
    lr_prep();
    tick();
    chk("rr_pop2_left", left, 16'h2000);
    chk("rr_pop2_right", right, 16'h2001);
    chk("rr_pop2_r1", r1, 1);
    tick();
    chk("rr_refill2_level", level, 4);
    lr_prep();
    tick();
    v0 = 1'b0; v1 = 1'b0;
    chk("rr_pop3_left", left, 16'h1000);
    chk("rr_pop3_level", level, 3);

    // Disable mid-run
    tick();
    chk("dis_pre_level", level, 3);
    enable = 1'b0; cfg = 16'h0055;
    tick();
    chk("dis_level", level, 0);
    chk("dis_left", left, 0);
    chk("dis_right", right, 0);
    chk("dis_cnt", ucnt, 0);
    chk("dis_running", running, 0);
    tick();
    chk("dis_presc", presc, 16'h0055);
    cfg = 16'h0066;
    tick();
    chk("dis_presc_track", presc, 16'h0066);

    // Synchronous reset mid-transfer
    enable = 1'b1;
    tick();
    v1 = 1'b1; s1l = 16'h7777; s1r = 16'h8888;
    #1;
    chk("rst_xfer_r1", r1, 1);
    rst_n = 1'b0;
    tick();
    chk("rst_xfer_level", level, 0);
    chk("rst_xfer_presc", presc, 0);
    chk("rst_xfer_running", running, 0);
    chk("rst_xfer_r1_low", r1, 0);
    chk("rst_xfer_left", left, 0);
    v1 = 1'b0;
    rst_n = 1'b1;
    tick();
    tick();
    chk("post_rst_level", level, 0);
    lr_prep();
    tick();
    chk("post_rst_running", running, 0);
    chk("post_rst_left", left, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
